// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the two-port dmem arbiter.
// Feature macro DMEM_ARB_RR_EN (round-robin) is consumed in dmem_arbiter.sv.
package dmem_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    localparam int unsigned PORT0 = 0;
    localparam int unsigned PORT1 = 1;

    // Misaligned or beyond the end of dmem; address is zero-extended by the caller.
    function automatic logic addr_bad(input logic [63:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way request picker: one-hot grant, pref selects the winner on a tie.
module dmem_arb_pick (
    input  logic [1:0] req,
    input  logic       pref,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = pref ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between the MEM stage (port 0) and the DMA/debug loader (port 1).
// Define DMEM_ARB_RR_EN for round-robin on ties; otherwise port 0 has fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned MAX_BURST   = 4
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,

    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CW-1:0] base_cnt;
    logic [1:0]    req_eff;
    logic [1:0]    pick_gnt;
    logic [1:0]    gnt;
    logic          pref;
    logic          bad0, bad1;
    logic          sel_we, sel_bad, sel_lock;
    logic          win;

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr_q;

    assign pref = rr_ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= 1'b0;
        end else if (|gnt) begin
            rr_ptr_q <= ~win;
        end
    end
`else
    assign pref = 1'b0;
`endif

    assign bad0 = addr_bad(64'(m0_addr), DEPTH_WORDS);
    assign bad1 = addr_bad(64'(m1_addr), DEPTH_WORDS);

    // A locked owner excludes the other port only while it keeps requesting.
    always_comb begin
        req_eff = {m1_req, m0_req};
        if (state_q == LOCK0 && m0_req) begin
            req_eff = 2'b01;
        end else if (state_q == LOCK1 && m1_req) begin
            req_eff = 2'b10;
        end
    end

    dmem_arb_pick u_pick (
        .req  (req_eff),
        .pref (pref),
        .gnt  (pick_gnt)
    );

    assign gnt    = pick_gnt & {2{reset_n}};
    assign m0_gnt = gnt[PORT0];
    assign m1_gnt = gnt[PORT1];
    assign win    = gnt[PORT1];

    always_comb begin
        mem_a    = '0;
        mem_wd   = '0;
        sel_we   = 1'b0;
        sel_bad  = 1'b0;
        sel_lock = 1'b0;
        if (gnt[PORT0]) begin
            mem_a    = m0_addr;
            mem_wd   = m0_wdata;
            sel_we   = m0_we;
            sel_bad  = bad0;
            sel_lock = m0_lock;
        end else if (gnt[PORT1]) begin
            mem_a    = m1_addr;
            mem_wd   = m1_wdata;
            sel_we   = m1_we;
            sel_bad  = bad1;
            sel_lock = m1_lock;
        end
    end

    assign mem_we = sel_we & ~sel_bad;

    // The count only carries over when the winner is the current lock owner.
    always_comb begin
        base_cnt = '0;
        if ((state_q == LOCK0 && !win) || (state_q == LOCK1 && win)) begin
            base_cnt = beat_cnt_q;
        end
    end

    always_comb begin
        state_d    = IDLE;
        beat_cnt_d = '0;
        if ((|gnt) && sel_lock && (32'(base_cnt) + 32'd1 < MAX_BURST)) begin
            state_d    = win ? LOCK1 : LOCK0;
            beat_cnt_d = base_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
        end else begin
            m0_rvalid <= gnt[PORT0];
            m0_rdata  <= (gnt[PORT0] && !m0_we && !bad0) ? mem_rd : '0;
            m0_err    <= gnt[PORT0] & bad0;
            m1_rvalid <= gnt[PORT1];
            m1_rdata  <= (gnt[PORT1] && !m1_we && !bad1) ? mem_rd : '0;
            m1_err    <= gnt[PORT1] & bad1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word dmem behind it.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:63];
    logic [29:0] idx;

    int checks = 0;
    int errors = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out-of-range reads return a poison pattern that must never reach rdata.
    assign idx    = mem_a[31:2];
    assign mem_rd = (idx < 30'd64) ? mem[idx[5:0]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (mem_we && idx < 30'd64) mem[idx[5:0]] <= mem_wd;
    end

    task automatic idle_all();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_all();
        m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
        @(negedge clk); #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_gnt_we got %b want 000", {m0_gnt, m1_gnt, mem_we});
        end
        checks++;
        if ({m0_rvalid, m1_rvalid, m0_err, m1_err, m0_rdata, m1_rdata} !== 68'd0) begin
            errors++;
            $display("FAIL reset_resp got rv=%b%b err=%b%b rd0=%h rd1=%h want all 0",
                     m0_rvalid, m1_rvalid, m0_err, m1_err, m0_rdata, m1_rdata);
        end
        @(negedge clk);
        idle_all();
        reset_n = 1;
    endtask

    task automatic test_read();
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 32'h8; m0_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_we} !== 3'b101 || mem_a !== 32'h8) begin
            errors++;
            $display("FAIL wr_gnt got gnt=%b%b we=%b a=%h want 10 1 8",
                     m0_gnt, m1_gnt, mem_we, mem_a);
        end
        @(posedge clk); #1;
        checks++;
        if ({m0_rvalid, m0_err, m0_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL wr_resp got rv=%b err=%b rd=%h want 1 0 0", m0_rvalid, m0_err, m0_rdata);
        end
        @(negedge clk);
        m0_we = 0;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_we} !== 3'b100) begin
            errors++;
            $display("FAIL rd_gnt got %b want 100", {m0_gnt, m1_gnt, mem_we});
        end
        @(posedge clk); #1;
        checks++;
        if ({m0_rvalid, m0_err, m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL rd_resp got rv=%b err=%b rd=%h want 1 0 deadbeef",
                     m0_rvalid, m0_err, m0_rdata);
        end
        @(negedge clk);
        idle_all();
        @(posedge clk); #1;
        checks++;
        if ({m0_rvalid, m1_rvalid, m0_rdata} !== 34'd0) begin
            errors++;
            $display("FAIL idle_resp got rv=%b%b rd=%h want 00 0", m0_rvalid, m1_rvalid, m0_rdata);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp [4];
`ifdef DMEM_ARB_RR_EN
        exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h0; m0_wdata = 32'd1;
        m1_req = 1; m1_we = 1; m1_addr = 32'h4; m1_wdata = 32'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({m1_gnt, m0_gnt} !== exp[i]) begin
                errors++;
                $display("FAIL arb_gnt[%0d] got %b want %b", i, {m1_gnt, m0_gnt}, exp[i]);
            end
            @(negedge clk);
        end
        idle_all();
        checks++;
        if (mem[0] !== 32'd1) begin
            errors++;
            $display("FAIL arb_mem0 got %h want 1", mem[0]);
        end
`ifdef DMEM_ARB_RR_EN
        checks++;
        if (mem[1] !== 32'd2) begin
            errors++;
            $display("FAIL arb_mem1 got %h want 2", mem[1]);
        end
`endif
    endtask

    task automatic test_burst();
        logic [1:0] exp [6];
`ifdef DMEM_ARB_RR_EN
        exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`else
        exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
`endif
        do_reset();
        m1_req = 1; m1_lock = 1; m1_addr = 32'h8;
        m0_addr = 32'h0;
        for (int i = 0; i < 6; i++) begin
            m0_req = (i >= 1);
            #1;
            checks++;
            if ({m1_gnt, m0_gnt} !== exp[i]) begin
                errors++;
                $display("FAIL burst_gnt[%0d] got %b want %b", i, {m1_gnt, m0_gnt}, exp[i]);
            end
            @(posedge clk); #1;
            checks++;
            if ({m1_rvalid, m0_rvalid} !== exp[i]) begin
                errors++;
                $display("FAIL burst_rv[%0d] got %b want %b", i, {m1_rvalid, m0_rvalid}, exp[i]);
            end
            @(negedge clk);
        end
        idle_all();
    endtask

    task automatic test_bad_addr();
        logic [31:0] addr [6];
        logic        we   [6];
        logic        xwe  [6];
        logic        xerr [6];
        logic [31:0] xrd  [6];
        addr = '{32'h4, 32'h100, 32'h6, 32'h6, 32'h100, 32'h4};
        we   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        xwe  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        xerr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        xrd  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11111111};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            m0_req = 1; m0_we = we[i]; m0_addr = addr[i];
            m0_wdata = (i == 0) ? 32'h11111111 : 32'h55;
            #1;
            checks++;
            if ({m0_gnt, mem_we} !== {1'b1, xwe[i]}) begin
                errors++;
                $display("FAIL bad_we[%0d] got gnt=%b we=%b want 1 %b", i, m0_gnt, mem_we, xwe[i]);
            end
            @(posedge clk); #1;
            checks++;
            if ({m0_rvalid, m0_err, m0_rdata} !== {1'b1, xerr[i], xrd[i]}) begin
                errors++;
                $display("FAIL bad_resp[%0d] got rv=%b err=%b rd=%h want 1 %b %h",
                         i, m0_rvalid, m0_err, m0_rdata, xerr[i], xrd[i]);
            end
            @(negedge clk);
        end
        idle_all();
    endtask

    task automatic test_lock_drop();
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 32'h0;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL drop_gnt0 got %b want 01", {m1_gnt, m0_gnt});
        end
        @(negedge clk);
        m1_req = 1; m1_addr = 32'h8;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL drop_locked got %b want 01", {m1_gnt, m0_gnt});
        end
        @(negedge clk);
        m0_req = 0;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL drop_handover got %b want 10", {m1_gnt, m0_gnt});
        end
        @(posedge clk); #1;
        checks++;
        if ({m1_rvalid, m1_err, m1_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL drop_resp got rv=%b err=%b rd=%h want 1 0 deadbeef",
                     m1_rvalid, m1_err, m1_rdata);
        end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m1_req = 1; m1_lock = 1; m1_we = 1; m1_addr = 32'hC; m1_wdata = 32'h33;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt, mem_we} !== 3'b101) begin
            errors++;
            $display("FAIL rst_mid_first got %b want 101", {m1_gnt, m0_gnt, mem_we});
        end
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 32'h0; m0_wdata = 32'h44;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt, mem_we} !== 3'b101) begin
            errors++;
            $display("FAIL rst_mid_locked got %b want 101", {m1_gnt, m0_gnt, mem_we});
        end
        @(posedge clk); #1;
        checks++;
        if (m1_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_rv got %b want 1", m1_rvalid);
        end
        #1;
        reset_n = 0;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_we, m0_rvalid, m1_rvalid} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_mid_async got %b want 00000",
                     {m0_gnt, m1_gnt, mem_we, m0_rvalid, m1_rvalid});
        end
        @(negedge clk);
        reset_n = 1;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_tie got %b want 01", {m1_gnt, m0_gnt});
        end
        @(negedge clk);
        idle_all();
    endtask

    initial begin
        test_reset();
        test_read();
        test_arbitration();
        test_burst();
        test_bad_addr();
        test_lock_drop();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
